code_flasher: RTL
=================

# code_flasher

Plays a 16-bit, four-digit code back to the player as one-hot LED patterns, one digit at a time, with blank gaps between digits. It is the output-side counterpart of the switch-entry path: entry turns a one-hot switch selection into a 4-bit digit, and this block turns each 4-bit digit back into a one-hot LED word. The game controller loads the target code here at round start, waits for `done`, then enables player entry.

## Interface
Parameters:
- `ON_CYCLES`, default 50_000_000: cycles each digit's LED is lit; must be ≥ 1.
- `GAP_CYCLES`, default 25_000_000: blank cycles after each digit; 0 is legal and means no gap.
- `CNT_W`, default 32: counter width; must hold max(`ON_CYCLES`, `GAP_CYCLES`) − 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled request to begin playback; honoured only in IDLE.
- `abort`  in  1  cancels playback and returns to IDLE with no `done` pulse.
- `code`  in  16  digit0 = `code[3:0]` … digit3 = `code[15:12]`; captured on the accepting cycle.
- `leds`  out  16  one-hot `1 << digit` while a digit is lit; 0 otherwise.
- `digit_idx`  out  2  index (0–3) of the digit currently shown or gapped; 0 in IDLE.
- `busy`  out  1  high in SHOW and GAP.
- `done`  out  1  single-cycle pulse when playback of all four digits completes.

## Operation
- FSM states: IDLE, SHOW, GAP. All outputs are registered.
- IDLE: `leds`=0, `busy`=0, `digit_idx`=0, `cnt`=0. If `start`=1 and `abort`=0, latch `code` into `code_q`, then go to SHOW with `digit_idx`=0 and `cnt`=0.
- SHOW: `leds` = `1 << code_q[4*digit_idx +: 4]`; `cnt` increments each cycle. When `cnt` = `ON_CYCLES`−1, clear `cnt` and:
  - go to GAP if `GAP_CYCLES` > 0;
  - otherwise advance the digit directly.
- GAP: `leds`=0; `cnt` increments. When `cnt` = `GAP_CYCLES`−1, clear `cnt` and advance the digit.
- Advance the digit:
  - if `digit_idx` < 3: increment it and go to SHOW;
  - if `digit_idx` = 3: go to IDLE, pulse `done` for one cycle, set `digit_idx` to 0.
- `start` while `busy`: ignored. `code` changes while `busy`: ignored, because `code_q` is used.
- `abort` in SHOW or GAP: next cycle is IDLE with `leds`=0, `busy`=0, `digit_idx`=0, `cnt`=0, and no `done`. `abort` in IDLE: no effect, and it blocks a simultaneous `start`.
- Repeated digits with `GAP_CYCLES`=0: `leds` stays constant across the digit boundary, but `digit_idx` still advances.
- `rst`: takes priority over everything. On the next edge all state clears; reset value of every output is 0 (`leds`, `digit_idx`, `busy`, `done`). `code_q` also clears to 0.

## Timing
- Let `start` be accepted at edge t. Then at t+1: `busy`=1, `leds` shows digit0, `digit_idx`=0.
- Let P = `ON_CYCLES` + `GAP_CYCLES`. Digit k is lit for the `ON_CYCLES` cycles starting at t+1+k·P, followed by `GAP_CYCLES` blank cycles.
- `done`=1 only at cycle t+1+4P. In that cycle `busy`=0 and `leds`=0.
- `start` asserted in the `done` cycle is accepted, because the FSM is in IDLE. The next playback begins at the following cycle, with no dead cycle.
- `done` and `busy` are never high together.
- `abort` takes effect one cycle after it is sampled.
- `rst` takes effect one cycle after it is sampled, including mid-SHOW and mid-GAP.

## Test plan
Bench parameters: `ON_CYCLES`=3, `GAP_CYCLES`=2 unless noted.
- **Basic playback.** Reset, then `code`=16'hA50F and pulse `start`. Required: `leds`=16'h8000 for 3 cycles, then 0 for 2; then 16'h0001 for 3, then 0 for 2; then 16'h0020 for 3, then 0 for 2; then 16'h0400 for 3, then 0 for 2. `done` pulses exactly 21 cycles after `start`; `busy` is high for exactly 20 cycles.
- **Ignored inputs while busy.** During basic playback, pulse `start` and change `code` to 16'hFFFF at cycle 7. Required: the output sequence is identical to the basic playback; only one `done` pulse.
- **Zero gap, repeated digits.** Use `GAP_CYCLES`=0 and `code`=16'h3333. Required: `leds`=16'h0008 held for 12 consecutive cycles; `digit_idx` steps 0,1,2,3 every 3 cycles; `done` pulses at cycle 13.
- **Abort and abort-vs-start.** Assert `abort` during digit 2's SHOW. Required: next cycle `leds`=0, `busy`=0, `digit_idx`=0, and `done` never pulses. Then assert `start` and `abort` together in IDLE. Required: no playback.
- **Back-to-back playback.** Hold `start` high continuously with `code`=16'h1234. Required: `done` pulses every 21 cycles, and `leds`=16'h0010 appears in the cycle after each `done`.
- **Reset mid-operation.** Assert `rst` in a GAP cycle of digit 1. Required: all outputs are 0 on the next cycle. A subsequent `start` with `code`=16'h0000 shows 16'h0001 four times.

Source files
------------

// File: rtl/code_flasher_if.sv
// Handshake bundle between the game controller (master) and code_flasher (slave).
interface code_flasher_if;
    logic        start;
    logic        abort;
    logic [15:0] code;
    logic [15:0] leds;
    logic [1:0]  digit_idx;
    logic        busy;
    logic        done;

    modport master (output start, abort, code, input leds, digit_idx, busy, done);
    modport slave  (input start, abort, code, output leds, digit_idx, busy, done);
endinterface

// File: rtl/code_flasher.sv
// Plays a four-digit code back as one-hot LED words, one digit per ON_CYCLES,
// separated by GAP_CYCLES blank cycles; pulses done after the last digit.
module code_flasher #(
    parameter int ON_CYCLES  = 50_000_000,
    parameter int GAP_CYCLES = 25_000_000,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    code_flasher_if.slave bus
);
    localparam int GAP_M1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_M1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      code_q;
    logic [1:0]       digit_q;
    logic [15:0]      leds_q;
    logic             busy_q;
    logic             done_q;

    logic [1:0]  digit_d;
    logic [15:0] leds_d;
    logic        show_end;
    logic        advance;

    always_comb begin
        digit_d  = digit_q + 2'd1;
        leds_d   = 16'd1 << code_q[{digit_d, 2'b00} +: 4];
        show_end = (state_q == SHOW) && (cnt_q == ON_LAST);
        // With no gap the SHOW terminal count advances the digit directly.
        advance  = ((state_q == GAP) && (cnt_q == GAP_LAST)) ||
                   (show_end && (GAP_CYCLES == 0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            digit_q <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.start && !bus.abort) begin
                    code_q  <= bus.code;
                    state_q <= SHOW;
                    cnt_q   <= '0;
                    digit_q <= '0;
                    busy_q  <= 1'b1;
                    leds_q  <= 16'd1 << bus.code[3:0];
                end
            end else if (bus.abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                digit_q <= '0;
                busy_q  <= 1'b0;
                leds_q  <= '0;
            end else if (advance) begin
                cnt_q <= '0;
                if (digit_q == 2'd3) begin
                    state_q <= IDLE;
                    digit_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    leds_q  <= '0;
                end else begin
                    state_q <= SHOW;
                    digit_q <= digit_d;
                    leds_q  <= leds_d;
                end
            end else if (show_end) begin
                cnt_q   <= '0;
                state_q <= GAP;
                leds_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.leds      = leds_q;
    assign bus.digit_idx = digit_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
